// File: rtl/muldiv_pkg.sv
// Shared op-code and FSM state types for the multiply/divide unit.
package muldiv_pkg;

  localparam int OP_BITS = 3;

  typedef enum logic [OP_BITS-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, subtract if it fits.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor keeps shifted below 2*divisor, so diff[WIDTH] is a clean borrow flag
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (MIPS style).
// Define MULDIV_FAST_MULT_EN for a single-cycle multiplier; divide stays iterative.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e             state, state_next;
  op_e                op_reg;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   a_reg, b_reg, mag;
  logic [2*WIDTH-1:0] acc;

  logic               accept, op_is_mul, op_is_div, op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_next, quo_next;

  logic               res_signed, res_is_div, neg_a, neg_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

  assign accept    = start && (state == IDLE || state == FIN);
  assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign op_is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

  // acc holds {partial product, remaining multiplier} or {remainder, quotient/dividend}
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag : '0)};

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .quo      (acc[WIDTH-1:0]),
    .divisor  (mag),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Signs are re-applied to the magnitude result only once, on the way out of FIN
  always_comb begin
    res_signed = (op_reg == OP_MULT) || (op_reg == OP_DIV);
    res_is_div = (op_reg == OP_DIV)  || (op_reg == OP_DIVU);
    neg_a      = res_signed && a_reg[WIDTH-1];
    neg_b      = res_signed && b_reg[WIDTH-1];
    prod       = (neg_a ^ neg_b) ? -acc : acc;
    quo        = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem        = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!res_is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (b_reg == '0) begin
      res_hi = a_reg;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, FIN: begin
        done       = (state == FIN);
        state_next = IDLE;
        if (start) begin
          if (op_is_mul) begin
`ifdef MULDIV_FAST_MULT_EN
            state_next = FIN;
`else
            state_next = MUL;
`endif
          end else if (op_is_div) begin
            state_next = DIV;
          end
        end
      end
      MUL, DIV: begin
        busy = 1'b1;
        if (abort)                            state_next = IDLE;
        else if (count == CW'(WIDTH - 1))     state_next = FIN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= OP_MULT;
      count       <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      mag         <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        MUL: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          count <= count + CW'(1);
        end
        DIV: begin
          acc   <= {rem_next, quo_next};
          count <= count + CW'(1);
        end
        FIN: begin
          hi <= res_hi;
          lo <= res_lo;
          if (res_is_div) div_by_zero <= (b_reg == '0);
        end
        default: ;
      endcase
      // A move issued in the done cycle is the younger write, so it overrides FIN
      if (accept) begin
        if (op_is_mul || op_is_div) begin
          op_reg <= op_e'(op);
          a_reg  <= a;
          b_reg  <= b;
          count  <= '0;
          if (op_is_mul) begin
            mag <= a_mag;
`ifdef MULDIV_FAST_MULT_EN
            acc <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
            acc <= {{WIDTH{1'b0}}, b_mag};
`endif
          end else begin
            mag <= b_mag;
            acc <= {{WIDTH{1'b0}}, a_mag};
          end
        end else if (op == OP_MTHI) begin
          hi <= a;
        end else if (op == OP_MTLO) begin
          lo <= a;
        end
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO register width (legal range 8..64, even).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-006 abort  input  1  cancels an operation in progress.
REQ-007 a  input  WIDTH  operand A (multiplicand or dividend; MTHI/MTLO source).
REQ-008 b  input  WIDTH  operand B (multiplier or divisor).
REQ-009 busy  output  1  iterative operation in progress.
REQ-010 done  output  1  single-cycle pulse: HI/LO just updated by MULT/DIV.
REQ-011 div_by_zero  output  1  sticky flag: last completed DIV/DIVU had b=0.
REQ-012 hi  output  WIDTH  HI register (product upper half or remainder).
REQ-013 lo  output  WIDTH  LO register (product lower half or quotient).

Function
REQ-014 FSM states SHALL be: IDLE, MUL, DIV, FIN; busy=1 exactly in MUL and DIV.
REQ-015 A start with op 0-3 in IDLE SHALL latch a, b, op at that edge and go to MUL (0/1) or DIV (2/3).
REQ-016 Iterative ops SHALL take WIDTH cycles in MUL/DIV (one shift-add or restoring-subtract step per cycle), then one cycle in FIN.
REQ-017 In FIN, hi/lo SHALL be written at the edge leaving FIN, done SHALL be 1 during FIN, and the FSM SHALL return to IDLE.
REQ-018 Accept-to-done latency SHALL be WIDTH+1 cycles; a new start SHALL be accepted in the cycle done is high (FIN counts as not busy).
REQ-019 start while busy=1 SHALL be ignored with no side effects.
REQ-020 MTHI/MTLO accepted in IDLE or FIN SHALL write a to hi/lo at the next edge; busy and done stay 0; the other register is unchanged.
REQ-021 Reserved op codes SHALL be ignored.
REQ-022 Signed ops SHALL iterate on magnitudes; product sign = sign(a) XOR sign(b); quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-023 Product SHALL be the full 2*WIDTH-bit result: hi=upper WIDTH bits, lo=lower WIDTH bits.
REQ-024 DIV with a=most-negative and b=-1 SHALL yield lo=most-negative (wrap), hi=0.
REQ-025 DIV/DIVU with b=0 SHALL yield lo=all-ones, hi=a, and set div_by_zero; any other completed DIV/DIVU clears it; MULT ops leave it unchanged.
REQ-026 abort=1 while busy SHALL return the FSM to IDLE at the next edge with hi, lo, and div_by_zero unchanged and no done pulse; abort in IDLE or FIN has no effect.
REQ-027 abort and start in the same cycle while busy: abort wins, start is ignored.

Reset
REQ-028 While rst_n=0: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, iteration counter=0; reset mid-operation discards the operation.
REQ-029 Reset deassertion SHALL NOT cause a done pulse; the first start is accepted in the first cycle after deassertion.

Configuration
REQ-030 Macro MULDIV_FAST_MULT_EN defined: MULT/MULTU SHALL compute in a single cycle, going IDLE->FIN directly (latency 1, busy never asserted for multiply); DIV is unchanged.
REQ-031 Macro undefined: multiply SHALL use the WIDTH-cycle iterative path of REQ-016.

Structure
REQ-032 Package muldiv_pkg SHALL hold the op-code enum typedef, the FSM state enum typedef, and the op-code constants.
REQ-033 The per-cycle restoring-divide step SHALL be a sub-module muldiv_div_step (combinational, WIDTH-parametrised); all other logic stays in muldiv_unit.

Verification
REQ-034 MULT a=-3 (0xFFFFFFFD), b=7, WIDTH=32 -> done 33 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-035 DIVU a=100, b=7 -> lo=14, hi=2; DIV a=-7, b=2 -> lo=-3, hi=-1; div_by_zero=0.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1.
REQ-037 Start MULTU, assert abort 10 cycles later with start=1 -> busy falls next cycle, no done, hi/lo keep prior values, second start not accepted.
REQ-038 MTHI a=0x1234 then MTLO a=0x5678 back-to-back -> hi=0x1234, lo=0x5678, busy/done never 1; back-to-back start in the done cycle is accepted.
REQ-039 With MULDIV_FAST_MULT_EN: MULTU 0xFFFFFFFF*2 -> done one cycle after accept, hi=1, lo=0xFFFFFFFE; rst_n low mid-DIV clears all outputs to 0.
